// File: rtl/fp_adder_arbiter.sv
// Round-robin sequencer sharing one external FP adder among N_REQ requesters.
// Operands are registered onto the adder, the result is captured after ADD_LAT cycles and returned with a handshake.
module fp_adder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [3*N_REQ-1:0]   req_rmode,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_underflow,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic [2:0]           add_rmode,
  input  logic [31:0]          add_result,
  input  logic                 add_overflow,
  input  logic                 add_underflow,
  output logic                 busy,
  output logic [CNT_W-1:0]     ops_done
);

  localparam int          IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NR  = N_REQ;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic [2:0]       add_rmode_q, add_rmode_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_unf_q, rsp_unf_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic [IDW-1:0]   pick;
  logic             pick_vld;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [2:0]       sel_rmode;

  // First valid requester scanning upward from the one after last_grant.
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = (32'(last_grant_q) + k) % NR;
      if (!pick_vld && req_valid[IDW'(idx)]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_rmode = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (pick == IDW'(i)) begin
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
        sel_rmode = req_rmode[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      gnt_id_q     <= '0;
      lat_cnt_q    <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_rmode_q  <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      lat_cnt_q    <= lat_cnt_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_rmode_q  <= add_rmode_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_unf_q    <= rsp_unf_d;
      ops_done_q   <= ops_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    lat_cnt_d    = lat_cnt_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_rmode_d  = add_rmode_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_unf_d    = rsp_unf_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          add_a_d     = sel_a;
          add_b_d     = sel_b;
          add_rmode_d = sel_rmode;
          gnt_id_d    = pick;
          lat_cnt_d   = 3'(ADD_LAT);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_result_d = add_result;
          rsp_ovf_d    = add_overflow;
          rsp_unf_d    = add_underflow;
          state_d      = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready[gnt_id_q]) begin
          last_grant_d = gnt_id_q;
          ops_done_d   = ops_done_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && pick_vld && !rst) req_ready[pick] = 1'b1;
    if (state_q == RESP) rsp_valid[gnt_id_q] = 1'b1;
    busy = (state_q != IDLE);
  end

  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign add_rmode     = add_rmode_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_unf_q;
  assign ops_done      = ops_done_q;

endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Round-robin arbiter and sequencer that shares one single-precision FP adder among N_REQ requesters. Each requester issues an operand pair and rounding mode through a valid/ready handshake. The block registers the operands onto the adder inputs and waits the adder's fixed latency. It then captures the result and flags and returns them to the granted requester through a valid/ready response handshake. The block sits between the FPU's client ports and the adder datapath, and the adder is instantiated outside it.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- ADD_LAT, 0: adder latency in cycles, 0..7. A value of 0 means the adder is combinational from add_a/add_b/add_rmode to add_result.
- CNT_W, 16: width of the completed-operation counter.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accept; one-hot or zero.
- req_a  in  32*N_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same packing as req_a.
- req_rmode  in  3*N_REQ  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- rsp_valid  out  N_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_result  out  32  result of the granted operation.
- rsp_overflow  out  1  overflow flag of the granted operation.
- rsp_underflow  out  1  underflow flag of the granted operation.
- add_a  out  32  registered operand A to the adder.
- add_b  out  32  registered operand B to the adder.
- add_rmode  out  3  registered rounding mode to the adder.
- add_result  in  32  adder result.
- add_overflow  in  1  adder overflow flag.
- add_underflow  in  1  adder underflow flag.
- busy  out  1  high whenever state is not IDLE.
- ops_done  out  CNT_W  count of completed response handshakes; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant g is the first index with req_valid high, searching last_grant+1, last_grant+2, … modulo N_REQ.
  - req_ready[g] is driven combinationally high in this cycle only; all other req_ready bits are 0.
  - On the handshake, latch req_a[g], req_b[g] and req_rmode[g] into add_a, add_b and add_rmode.
  - Also latch g into gnt_id, load lat_cnt with ADD_LAT, and go to WAIT.
  - If no req_valid bit is high, stay in IDLE.
- WAIT:
  - If lat_cnt equals 0, capture add_result, add_overflow and add_underflow into the response registers and go to RESP.
  - Otherwise decrement lat_cnt.
  - add_a, add_b and add_rmode hold stable throughout WAIT.
- RESP:
  - rsp_valid[gnt_id] is high and all other rsp_valid bits are 0.
  - rsp_result and both flags hold stable.
  - On rsp_ready[gnt_id]: last_grant ← gnt_id, ops_done increments, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- req_ready is 0 in WAIT and RESP. A new request is never accepted in the same cycle a response completes.
- A requester may drop req_valid before it is granted; the arbiter keeps no memory of the withdrawn request.
- Operand values are sampled only in the handshake cycle.

## Timing
- Reset values:
  - state IDLE, busy 0.
  - last_grant = N_REQ-1, so requester 0 wins first.
  - gnt_id 0, lat_cnt 0.
  - add_a, add_b and add_rmode all 0.
  - rsp_valid 0, rsp_result 0, both flags 0.
  - ops_done 0.
  - req_ready is 0 during the reset cycle.
- Latency: request accepted in cycle t gives rsp_valid high from cycle t+2+ADD_LAT.
- Occupancy per operation, with rsp_ready held high: ADD_LAT+3 cycles (accept, ADD_LAT+1 cycles in WAIT, 1 cycle in RESP). The next accept is possible in the following IDLE cycle.
- The response is held indefinitely under backpressure, with no loss and no re-arbitration.
- Reset mid-operation (WAIT or RESP): the in-flight operation is dropped with no response. All registers return to their reset values on the next edge.
- ops_done wraps from 2^CNT_W-1 to 0.

## Test plan
- Single request: ADD_LAT=0, requester 0 sends a=0x3F800000, b=0x40000000, rmode 000.
  - Required: req_ready[0] high in the accept cycle.
  - Required: rsp_valid[0] high 2 cycles later with rsp_result 0x40400000, both flags 0.
  - Required: ops_done becomes 1 after the response handshake.
- Fairness: all 4 requesters hold req_valid high from reset, rsp_ready all high.
  - Required: grants occur in order 0,1,2,3,0,1.
  - Required: successive accepts are spaced 3 cycles apart.
- Backpressure: rsp_ready[1] held low for 5 cycles while requester 0 also requests.
  - Required: rsp_valid[1] and rsp_result stay unchanged throughout.
  - Required: req_ready stays 0 throughout.
  - Required: requester 0 is granted in the first IDLE cycle after the rsp_ready[1] handshake.
- Latency parameter: ADD_LAT=2, using the single-request stimulus.
  - Required: rsp_valid appears exactly 4 cycles after the accept.
  - Required: add_a and add_b stay constant across the 3 WAIT cycles.
- Subnormal pass-through: requester 2 sends a=b=0x000a0000 with rmode 001.
  - Required: add_rmode equals 001 during WAIT.
  - Required: rsp_result is 0x00140000 on rsp_valid[2].
- Reset mid-operation: rst asserted for 1 cycle while in WAIT.
  - Required: no rsp_valid occurs and busy is 0 on the next cycle.
  - Required: ops_done is 0.
  - Required: the next simultaneous requests from 0 and 3 grant requester 0.
